// File: rtl/v_ram_word_reader.sv
// Read sequencer for the 32-bit RAM port: walks a word range and streams the words out on valid/ready.
// Define RD_CHECKSUM_EN to add a running XOR checksum output of every delivered word.
module v_ram_word_reader #(
    parameter int WIDTH     = 32,
    parameter int ADDRWIDTH = 6,
    parameter int CNTWIDTH  = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDRWIDTH-1:0] baseAddr,
    input  logic [CNTWIDTH-1:0]  wordCount,
    output logic                 busy,
    output logic                 done,
    output logic                 ramEn,
    output logic [ADDRWIDTH-1:0] ramAddr,
    input  logic [WIDTH-1:0]     ramDo,
    output logic [WIDTH-1:0]     dataOut,
    output logic                 validOut,
    input  logic                 readyOut
`ifdef RD_CHECKSUM_EN
    ,
    output logic [WIDTH-1:0]     checksum
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

    state_t               state;
    logic [CNTWIDTH-1:0]  remaining;
    logic                 inflight;
    logic [WIDTH-1:0]     fifo_mem [2];
    logic                 rd_ptr;
    logic                 wr_ptr;
    logic [1:0]           count;
    logic                 push;
    logic                 pop;
    logic [2:0]           pending;

    // A word landing from the RAM into an empty buffer is offered directly, saving a cycle of latency.
    assign push     = inflight;
    assign validOut = (count != 2'd0) || inflight;
    assign dataOut  = (count != 2'd0) ? fifo_mem[rd_ptr] : (inflight ? ramDo : '0);
    assign pop      = validOut && readyOut;
    assign pending  = {1'b0, count} + {2'b0, inflight};
    assign ramEn    = (state == RUN) && (pending < (3'd2 + {2'b0, pop}));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= ramDo;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            ramAddr   <= '0;
            remaining <= '0;
            inflight  <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= ramEn;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (wordCount != '0) begin
                            ramAddr   <= baseAddr;
                            remaining <= wordCount;
                            busy      <= 1'b1;
                            state     <= RUN;
                        end else begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end
                    end
                end
                RUN: begin
                    if (ramEn) begin
                        ramAddr   <= ramAddr + ADDRWIDTH'(1);
                        remaining <= remaining - CNTWIDTH'(1);
                        if (remaining == CNTWIDTH'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Finish as soon as the last word is being taken this cycle, so done follows the final handshake.
                    if (pending == {2'b0, pop}) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef RD_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum <= '0;
        end else if ((state == IDLE) && start) begin
            checksum <= '0;
        end else if (pop) begin
            checksum <= checksum ^ dataOut;
        end
    end
`endif

endmodule

// File: tb/tb_v_ram_word_reader.sv
// Directed bench for v_ram_word_reader with a behavioural registered-read RAM on the wide port.
// Observation index j counts clock edges after the edge that samples start (j=0 is the first cycle after it).
module tb_v_ram_word_reader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [5:0]  baseAddr;
    logic [6:0]  wordCount;
    logic        busy;
    logic        done;
    logic        ramEn;
    logic [5:0]  ramAddr;
    logic [31:0] ramDo;
    logic [31:0] dataOut;
    logic        validOut;
    logic        readyOut;
`ifdef RD_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int errors;
    int checks;

    logic [31:0] ram [64];
    logic [31:0] gotQ [$];
    int          addrQ [$];
    int          firstValid;
    int          lastHs;
    int          doneAt;
    int          fullViol;
    int          unstable;
    int          ramEnCount;
    int          validCount;
    int          timedOut;
    logic        busyFirst;
    logic        busyAtDone;
    logic        doneAfter;
    logic [31:0] sumAtDone;

    v_ram_word_reader dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .baseAddr(baseAddr),
        .wordCount(wordCount),
        .busy(busy),
        .done(done),
        .ramEn(ramEn),
        .ramAddr(ramAddr),
        .ramDo(ramDo),
        .dataOut(dataOut),
        .validOut(validOut),
        .readyOut(readyOut)
`ifdef RD_CHECKSUM_EN
        ,
        .checksum(checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ramEn) ramDo <= ram[ramAddr];
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic run_xfer(input logic [5:0] base, input logic [6:0] cnt, input int mode);
        int outstanding;
        logic prevStall;
        logic [31:0] prevData;
        logic pop;
        gotQ.delete();
        addrQ.delete();
        firstValid = -1; lastHs = -1; doneAt = -1;
        fullViol = 0; unstable = 0; ramEnCount = 0; validCount = 0; timedOut = 1;
        busyFirst = 1'b0; busyAtDone = 1'b1; doneAfter = 1'b1; sumAtDone = '0;
        @(negedge clk);
        start = 1'b1; baseAddr = base; wordCount = cnt; readyOut = 1'b0;
        @(negedge clk);
        start = 1'b0;
        outstanding = 0; prevStall = 1'b0; prevData = '0;
        for (int j = 0; j < 400; j++) begin
            readyOut = (mode == 0) ? 1'b1 : ((j % 4 == 0) || (j % 4 == 3));
            #1;
            pop = validOut & readyOut;
            if (j == 0) busyFirst = busy;
            if (ramEn) begin
                ramEnCount++;
                addrQ.push_back(int'(ramAddr));
                if (outstanding - int'(pop) >= 2) fullViol++;
            end
            if (prevStall && (!validOut || dataOut !== prevData)) unstable++;
            if (validOut) begin
                validCount++;
                if (firstValid < 0) firstValid = j;
            end
            if (pop) begin
                gotQ.push_back(dataOut);
                lastHs = j;
            end
            outstanding = outstanding + int'(ramEn) - int'(pop);
            prevStall = validOut & ~readyOut;
            prevData = dataOut;
            if (done) begin
                doneAt = j;
                busyAtDone = busy;
`ifdef RD_CHECKSUM_EN
                sumAtDone = checksum;
`endif
                timedOut = 0;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        #1;
        doneAfter = done;
        readyOut = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; baseAddr = '0; wordCount = '0; readyOut = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %0b expected 0", done); end
        checks++; if (ramEn !== 1'b0) begin errors++; $display("[TB] FAIL reset_ramEn: got %0b expected 0", ramEn); end
        checks++; if (ramAddr !== 6'd0) begin errors++; $display("[TB] FAIL reset_ramAddr: got %0d expected 0", ramAddr); end
        checks++; if (validOut !== 1'b0) begin errors++; $display("[TB] FAIL reset_validOut: got %0b expected 0", validOut); end
        checks++; if (dataOut !== 32'h0) begin errors++; $display("[TB] FAIL reset_dataOut: got %0h expected 0", dataOut); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stream();
        run_xfer(6'd4, 7'd8, 0);
        checks++; if (timedOut != 0) begin errors++; $display("[TB] FAIL stream_timeout: got %0d expected 0", timedOut); end
        checks++; if (gotQ.size() != 8) begin errors++; $display("[TB] FAIL stream_count: got %0d expected 8", gotQ.size()); end
        for (int i = 0; i < 8 && i < gotQ.size(); i++) begin
            checks++;
            if (gotQ[i] !== 32'hA5000004 + i) begin
                errors++; $display("[TB] FAIL stream_word%0d: got %0h expected %0h", i, gotQ[i], 32'hA5000004 + i);
            end
        end
        checks++; if (firstValid != 1) begin errors++; $display("[TB] FAIL stream_latency: got %0d expected 1", firstValid); end
        checks++; if (lastHs != 8) begin errors++; $display("[TB] FAIL stream_throughput: last handshake %0d expected 8", lastHs); end
        checks++; if (doneAt != 9) begin errors++; $display("[TB] FAIL stream_done_time: got %0d expected 9", doneAt); end
        checks++; if (busyFirst !== 1'b1) begin errors++; $display("[TB] FAIL stream_busy: got %0b expected 1", busyFirst); end
        checks++; if (busyAtDone !== 1'b0) begin errors++; $display("[TB] FAIL stream_busy_at_done: got %0b expected 0", busyAtDone); end
        checks++; if (doneAfter !== 1'b0) begin errors++; $display("[TB] FAIL stream_done_pulse: got %0b expected 0", doneAfter); end
    endtask

    task automatic test_backpressure();
        run_xfer(6'd4, 7'd8, 1);
        checks++; if (timedOut != 0) begin errors++; $display("[TB] FAIL bp_timeout: got %0d expected 0", timedOut); end
        checks++; if (gotQ.size() != 8) begin errors++; $display("[TB] FAIL bp_count: got %0d expected 8", gotQ.size()); end
        for (int i = 0; i < 8 && i < gotQ.size(); i++) begin
            checks++;
            if (gotQ[i] !== 32'hA5000004 + i) begin
                errors++; $display("[TB] FAIL bp_word%0d: got %0h expected %0h", i, gotQ[i], 32'hA5000004 + i);
            end
        end
        checks++; if (unstable != 0) begin errors++; $display("[TB] FAIL bp_stable: got %0d unstable cycles expected 0", unstable); end
        checks++; if (fullViol != 0) begin errors++; $display("[TB] FAIL bp_overissue: got %0d expected 0", fullViol); end
        checks++; if (ramEnCount != 8) begin errors++; $display("[TB] FAIL bp_reads: got %0d expected 8", ramEnCount); end
    endtask

    task automatic test_wrap();
        int expAddr [4];
        expAddr = '{62, 63, 0, 1};
        run_xfer(6'd62, 7'd4, 0);
        checks++; if (addrQ.size() != 4) begin errors++; $display("[TB] FAIL wrap_reads: got %0d expected 4", addrQ.size()); end
        for (int i = 0; i < 4 && i < addrQ.size(); i++) begin
            checks++;
            if (addrQ[i] != expAddr[i]) begin
                errors++; $display("[TB] FAIL wrap_addr%0d: got %0d expected %0d", i, addrQ[i], expAddr[i]);
            end
        end
        checks++; if (gotQ.size() != 4) begin errors++; $display("[TB] FAIL wrap_count: got %0d expected 4", gotQ.size()); end
        for (int i = 0; i < 4 && i < gotQ.size(); i++) begin
            checks++;
            if (gotQ[i] !== 32'hA5000000 + expAddr[i]) begin
                errors++; $display("[TB] FAIL wrap_word%0d: got %0h expected %0h", i, gotQ[i], 32'hA5000000 + expAddr[i]);
            end
        end
        checks++; if (doneAt != 5) begin errors++; $display("[TB] FAIL wrap_done_time: got %0d expected 5", doneAt); end
    endtask

    task automatic test_zero_count();
        run_xfer(6'd10, 7'd0, 0);
        checks++; if (timedOut != 0) begin errors++; $display("[TB] FAIL zero_timeout: got %0d expected 0", timedOut); end
        checks++; if (ramEnCount != 0) begin errors++; $display("[TB] FAIL zero_ramEn: got %0d reads expected 0", ramEnCount); end
        checks++; if (validCount != 0) begin errors++; $display("[TB] FAIL zero_valid: got %0d valid cycles expected 0", validCount); end
        checks++; if (doneAt != 0) begin errors++; $display("[TB] FAIL zero_done_time: got %0d expected 0", doneAt); end
        checks++; if (busyFirst !== 1'b0) begin errors++; $display("[TB] FAIL zero_busy: got %0b expected 0", busyFirst); end
    endtask

    task automatic test_reset_mid();
        int hs;
        int doneSeen;
        hs = 0; doneSeen = 0;
        @(negedge clk);
        start = 1'b1; baseAddr = 6'd0; wordCount = 7'd16; readyOut = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < 50 && hs < 3; j++) begin
            #1;
            if (validOut && readyOut) hs++;
            if (hs < 3) @(negedge clk);
        end
        checks++; if (hs != 3) begin errors++; $display("[TB] FAIL mid_progress: got %0d words expected 3", hs); end
        #1 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy: got %0b expected 0", busy); end
        checks++; if (ramEn !== 1'b0) begin errors++; $display("[TB] FAIL mid_ramEn: got %0b expected 0", ramEn); end
        checks++; if (ramAddr !== 6'd0) begin errors++; $display("[TB] FAIL mid_ramAddr: got %0d expected 0", ramAddr); end
        checks++; if (validOut !== 1'b0) begin errors++; $display("[TB] FAIL mid_validOut: got %0b expected 0", validOut); end
        checks++; if (dataOut !== 32'h0) begin errors++; $display("[TB] FAIL mid_dataOut: got %0h expected 0", dataOut); end
        @(negedge clk);
        rst = 1'b0; readyOut = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            #1;
            if (done || busy) doneSeen++;
        end
        checks++; if (doneSeen != 0) begin errors++; $display("[TB] FAIL mid_no_done: got %0d active cycles expected 0", doneSeen); end
        run_xfer(6'd0, 7'd2, 0);
        checks++; if (gotQ.size() != 2) begin errors++; $display("[TB] FAIL mid_restart_count: got %0d expected 2", gotQ.size()); end
        for (int i = 0; i < 2 && i < gotQ.size(); i++) begin
            checks++;
            if (gotQ[i] !== 32'hA5000000 + i) begin
                errors++; $display("[TB] FAIL mid_restart_word%0d: got %0h expected %0h", i, gotQ[i], 32'hA5000000 + i);
            end
        end
        checks++; if (doneAt != 3) begin errors++; $display("[TB] FAIL mid_restart_done: got %0d expected 3", doneAt); end
    endtask

`ifdef RD_CHECKSUM_EN
    task automatic test_checksum();
        ram[20] = 32'h1; ram[21] = 32'h2; ram[22] = 32'h4; ram[23] = 32'h8;
        run_xfer(6'd20, 7'd4, 1);
        checks++; if (sumAtDone !== 32'h0000000F) begin errors++; $display("[TB] FAIL checksum_done: got %0h expected f", sumAtDone); end
        checks++; if (checksum !== 32'h0000000F) begin errors++; $display("[TB] FAIL checksum_hold: got %0h expected f", checksum); end
        for (int i = 20; i < 24; i++) ram[i] = 32'hA5000000 + i;
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < 64; i++) ram[i] = 32'hA5000000 + i;
        test_reset();
        test_stream();
        test_backpressure();
        test_wrap();
        test_zero_count();
        test_reset_mid();
`ifdef RD_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
